// File: rtl/psched_pkg.sv
// Shared types and constants for the parity-count scheduler.
// FSM state encoding and the per-requester sample width.
package psched_pkg;

    localparam int SAMPLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority starting after last grant.
// last_grant moves only when the granted requester actually transfers.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   probe;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = last_grant;
        found   = 1'b0;
        probe   = '0;
        for (int k = 1; k <= N; k++) begin
            probe = {1'b0, last_grant} + (IW+1)'(k);
            if (probe >= (IW+1)'(N)) probe = probe - (IW+1)'(N);
            if (!found && req[probe[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = probe[IW-1:0];
            end
        end
        if (en && found) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) last_grant <= IW'(N - 1);
        else if (advance) last_grant <= gnt_idx;
    end

endmodule

// File: rtl/parity_count_scheduler.sv
// Window FSM, odd/even tallies and result registers around rr_arbiter.
// Optional idle timeout close: define PSCHED_TIMEOUT_EN.
module parity_count_scheduler
    import psched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WINDOW  = 16,
    parameter int TIMEOUT = 32,
    parameter int CW      = $clog2(WINDOW + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_REQ-1:0]          req,
    input  logic [SAMPLE_W*N_REQ-1:0] d_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [CW-1:0]             count_odd,
    output logic [CW-1:0]             count_even,
    output logic                      timed_out
);

    state_t state, state_nx;

    logic [CW-1:0]    odd_t, even_t, n_acc;
    logic [CW-1:0]    odd_nx, even_nx;
    logic [N_REQ-1:0] lsb;
    logic             xfer, odd_bit, to_hit, close;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer),
        .en      (state == S_RUN),
        .gnt     (gnt)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) lsb[i] = d_in[SAMPLE_W*i];
    end

    assign xfer    = |(req & gnt);
    assign odd_bit = |(gnt & lsb);
    assign odd_nx  = odd_t + CW'(xfer && odd_bit);
    assign even_nx = even_t + CW'(xfer && !odd_bit);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_RUN;
            S_RUN: begin
                if (xfer && n_acc == CW'(WINDOW - 1)) state_nx = S_REPORT;
                else if (to_hit) state_nx = S_REPORT;
            end
            S_REPORT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign close = (state == S_RUN) && (state_nx == S_REPORT);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_REPORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            odd_t      <= '0;
            even_t     <= '0;
            n_acc      <= '0;
            count_odd  <= '0;
            count_even <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                odd_t  <= '0;
                even_t <= '0;
                n_acc  <= '0;
            end else if (state == S_RUN && xfer) begin
                odd_t  <= odd_nx;
                even_t <= even_nx;
                n_acc  <= n_acc + 1'b1;
            end
            // Totals land with the closing transfer so they show in REPORT
            if (close) begin
                count_odd  <= odd_nx;
                count_even <= even_nx;
            end
        end
    end

`ifdef PSCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          to_r;

    assign to_hit = (state == S_RUN) && !(|req)
                 && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            to_r     <= 1'b0;
        end else begin
            if (state != S_RUN || xfer) idle_cnt <= '0;
            else if (!(|req)) idle_cnt <= idle_cnt + 1'b1;
            if (close) to_r <= to_hit;
        end
    end

    assign timed_out = to_r;
`else
    assign to_hit    = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_parity_count_scheduler.sv
// Randomized and directed bench for parity_count_scheduler.
// Reference model: spec-level round robin and odd/even tallies.
module tb_parity_count_scheduler;

    localparam int N = 4;
    localparam int W = 4;

    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic [3:0]  req = 0;
    logic [15:0] d_in = 0;
    logic [3:0]  gnt;
    logic        busy, done, timed_out;
    logic [2:0]  count_odd, count_even;

    logic        start_b = 0;
    logic [1:0]  req_b = 0;
    logic [7:0]  d_b = 0;
    logic [1:0]  gnt_b;
    logic        busy_b, done_b, to_b;
    logic [0:0]  co_b, ce_b;

    int checks = 0;
    int errors = 0;
    int mlast  = N - 1;

    always #5 clk = ~clk;

    parity_count_scheduler #(
        .N_REQ(N), .WINDOW(W), .TIMEOUT(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .req(req),
        .d_in(d_in), .gnt(gnt), .busy(busy), .done(done),
        .count_odd(count_odd), .count_even(count_even),
        .timed_out(timed_out)
    );

    parity_count_scheduler #(
        .N_REQ(2), .WINDOW(1), .TIMEOUT(5)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .req(req_b),
        .d_in(d_b), .gnt(gnt_b), .busy(busy_b), .done(done_b),
        .count_odd(co_b), .count_even(ce_b), .timed_out(to_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int j = 1; j <= N; j++) begin
            if (r[(last + j) % N]) return (last + j) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1; req = 4'hF; req_b = 2'b11;
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if (gnt !== 4'b0) begin
            errors++; $display("FAIL reset_gnt got %b want 0", gnt);
        end
        checks++;
        if (busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b want 0", busy, done);
        end
        checks++;
        if (count_odd !== 0 || count_even !== 0 || timed_out !== 0) begin
            errors++;
            $display("FAIL reset_counts odd=%0d even=%0d to=%b want 0",
                     count_odd, count_even, timed_out);
        end
        checks++;
        if (gnt_b !== 0 || busy_b !== 0 || co_b !== 0 || ce_b !== 0) begin
            errors++; $display("FAIL reset_b gnt=%b busy=%b want 0",
                               gnt_b, busy_b);
        end
        req = 0; req_b = 0;
        mlast = N - 1;
        tick();
    endtask

    task automatic test_directed();
        logic [3:0] v[4];
        v[0] = 3; v[1] = 10; v[2] = 11; v[3] = 10;
        start = 1; tick(); start = 0;
        checks++;
        if (busy !== 1) begin
            errors++; $display("FAIL dir_busy got %b want 1", busy);
        end
        for (int k = 0; k < 4; k++) begin
            req = 4'b0001; d_in = {12'h0, v[k]};
            #1;
            checks++;
            if (gnt !== 4'b0001) begin
                errors++; $display("FAIL dir_gnt%0d got %b want 0001",
                                   k, gnt);
            end
            tick();
        end
        mlast = 0;
        checks++;
        if (done !== 1 || count_odd !== 2 || count_even !== 2) begin
            errors++;
            $display("FAIL dir_report done=%b odd=%0d even=%0d want 1 2 2",
                     done, count_odd, count_even);
        end
        checks++;
        if (gnt !== 4'b0) begin
            errors++; $display("FAIL dir_report_gnt got %b want 0", gnt);
        end
        req = 0;
        tick();
        checks++;
        if (done !== 0 || busy !== 0 || count_odd !== 2) begin
            errors++;
            $display("FAIL dir_after done=%b busy=%b odd=%0d want 0 0 2",
                     done, busy, count_odd);
        end
    endtask

    task automatic test_round_robin();
        int eo = 0, ee = 0, idx;
        start = 1; tick(); start = 0;
        req = 4'hF;
        for (int k = 0; k < W; k++) begin
            d_in = 16'($urandom);
            #1;
            idx = (mlast + 1) % N;
            checks++;
            if (gnt !== 4'(1 << idx)) begin
                errors++; $display("FAIL rr_gnt%0d got %b want %b",
                                   k, gnt, 4'(1 << idx));
            end
            if (d_in[4*idx]) eo++; else ee++;
            mlast = idx;
            tick();
        end
        checks++;
        if (done !== 1 || count_odd !== 3'(eo) || count_even !== 3'(ee)) begin
            errors++;
            $display("FAIL rr_report done=%b odd=%0d even=%0d want 1 %0d %0d",
                     done, count_odd, count_even, eo, ee);
        end
        req = 0;
        tick();
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        start = 1; tick();
        req = 0; #1;
        checks++;
        if (gnt !== 0) begin
            errors++; $display("FAIL ign_idle_gnt got %b want 0", gnt);
        end
        tick();
        checks++;
        if (busy !== 1) begin
            errors++; $display("FAIL ign_busy got %b want 1", busy);
        end
        for (int k = 0; k < W; k++) begin
            req = 4'b0001; d_in = 16'h0001;
            if (done) ndone++;
            tick();
        end
        mlast = 0;
        req = 4'hF; #1;
        if (done) ndone++;
        checks++;
        if (gnt !== 0 || count_odd !== 4 || count_even !== 0) begin
            errors++;
            $display("FAIL ign_report gnt=%b odd=%0d even=%0d want 0 4 0",
                     gnt, count_odd, count_even);
        end
        start = 0; req = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (busy !== 0 || ndone !== 1) begin
            errors++; $display("FAIL ign_dones busy=%b dones=%0d want 0 1",
                               busy, ndone);
        end
    endtask

    task automatic test_mid_reset();
        int eo = 0, ee = 0, idx;
        start = 1; tick(); start = 0;
        for (int k = 0; k < 3; k++) begin
            req = 4'b0001; d_in = 16'h0001;
            tick();
        end
        rst = 1; req = 0;
        tick();
        rst = 0;
        mlast = N - 1;
        checks++;
        if (busy !== 0 || done !== 0 || gnt !== 0) begin
            errors++; $display("FAIL mrst_flags busy=%b done=%b gnt=%b",
                               busy, done, gnt);
        end
        checks++;
        if (count_odd !== 0 || count_even !== 0) begin
            errors++; $display("FAIL mrst_counts odd=%0d even=%0d want 0",
                               count_odd, count_even);
        end
        start = 1; tick(); start = 0;
        for (int k = 0; k < W; k++) begin
            req = 4'b1010; d_in = 16'($urandom);
            #1;
            idx = rr_pick(req, mlast);
            checks++;
            if (gnt !== 4'(1 << idx)) begin
                errors++; $display("FAIL mrst_gnt%0d got %b want %b",
                                   k, gnt, 4'(1 << idx));
            end
            if (d_in[4*idx]) eo++; else ee++;
            mlast = idx;
            tick();
        end
        checks++;
        if (done !== 1 || count_odd !== 3'(eo) || count_even !== 3'(ee)) begin
            errors++;
            $display("FAIL mrst_report done=%b odd=%0d even=%0d want 1 %0d %0d",
                     done, count_odd, count_even, eo, ee);
        end
        req = 0;
        tick();
    endtask

    task automatic test_window1();
        start_b = 1; tick(); start_b = 0;
        req_b = 2'b01; d_b = 8'h00; #1;
        checks++;
        if (gnt_b !== 2'b01) begin
            errors++; $display("FAIL w1_gnt0 got %b want 01", gnt_b);
        end
        tick();
        req_b = 0;
        checks++;
        if (done_b !== 1 || co_b !== 0 || ce_b !== 1) begin
            errors++; $display("FAIL w1_zero done=%b odd=%0d even=%0d",
                               done_b, co_b, ce_b);
        end
        tick();
        start_b = 1; tick(); start_b = 0;
        req_b = 2'b10; d_b = 8'hF0; #1;
        checks++;
        if (gnt_b !== 2'b10) begin
            errors++; $display("FAIL w1_gnt1 got %b want 10", gnt_b);
        end
        tick();
        req_b = 0;
        checks++;
        if (done_b !== 1 || co_b !== 1 || ce_b !== 0) begin
            errors++; $display("FAIL w1_fifteen done=%b odd=%0d even=%0d",
                               done_b, co_b, ce_b);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] val[4];
        int eo, ee, n, idx, cyc;
        pend = 0;
        for (int w = 0; w < 6; w++) begin
            eo = 0; ee = 0; n = 0; cyc = 0;
            start = 1; tick(); start = 0;
            while (n < W && cyc < 200) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && ($urandom % 3 == 0)) begin
                        pend[i] = 1;
                        val[i] = 4'($urandom);
                    end
                    d_in[4*i +: 4] = val[i];
                end
                req = pend;
                #1;
                idx = rr_pick(pend, mlast);
                checks++;
                if (idx < 0 ? gnt !== 0 : gnt !== 4'(1 << idx)) begin
                    errors++; $display("FAIL rnd_gnt w%0d got %b req %b",
                                       w, gnt, pend);
                end
                if (idx >= 0) begin
                    if (val[idx][0]) eo++; else ee++;
                    pend[idx] = 0;
                    mlast = idx;
                    n++;
                end
                cyc++;
                tick();
            end
            checks++;
            if (n < W) begin
                errors++; $display("FAIL rnd_timeout w%0d got %0d want %0d",
                                   w, n, W);
            end
            req = pend;
            #1;
            checks++;
            if (done !== 1 || count_odd !== 3'(eo) || count_even !== 3'(ee)
                || gnt !== 0) begin
                errors++;
                $display("FAIL rnd_report w%0d odd=%0d even=%0d want %0d %0d",
                         w, count_odd, count_even, eo, ee);
            end
            tick();
        end
        req = 0;
        tick();
    endtask

`ifdef PSCHED_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        start = 1; tick(); start = 0;
        req = 4'b0001; d_in = 16'h0009; tick();
        req = 4'b0001; d_in = 16'h0004; tick();
        mlast = 0;
        req = 0;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 5) begin
            errors++; $display("FAIL to_latency got %0d want 5", cnt);
        end
        checks++;
        if (count_odd !== 1 || count_even !== 1 || timed_out !== 1) begin
            errors++; $display("FAIL to_report odd=%0d even=%0d to=%b",
                               count_odd, count_even, timed_out);
        end
        tick();
        start = 1; tick(); start = 0;
        for (int k = 0; k < W; k++) begin
            req = 4'b0001; d_in = 16'h0002; tick();
        end
        checks++;
        if (done !== 1 || timed_out !== 0 || count_even !== 4) begin
            errors++; $display("FAIL to_clear done=%b to=%b even=%0d",
                               done, timed_out, count_even);
        end
        req = 0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_start_ignored();
        test_mid_reset();
        test_window1();
        test_random();
`ifdef PSCHED_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (timed_out !== 0) begin
            errors++; $display("FAIL to_tied got %b want 0", timed_out);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_count_scheduler.md
# parity_count_scheduler

Window controller and round-robin arbiter for the odd/even sample-counting datapath. N_REQ requesters each present a 4-bit sample with a request. The block grants one requester per cycle and classifies the granted sample as odd or even. It closes a counting window after WINDOW accepted samples and reports the odd and even totals with a one-cycle done pulse. It sits between the sample producers and the result consumer, and it owns sequencing and clearing of the tallies.

## Interface
- N_REQ, 4: number of requesters, 2..8
- WINDOW, 16: accepted samples per window, ≥1
- TIMEOUT, 32: idle cycles before early window close (only with PSCHED_TIMEOUT_EN)
- CW, $clog2(WINDOW+1): width of the tally and total outputs
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; opens a window when idle
- req  in  N_REQ  per-requester request; held high until granted
- d_in  in  4*N_REQ  samples; requester i drives bits [4i+3:4i]; stable while req[i] is high
- gnt  out  N_REQ  one-hot grant; req[i]&gnt[i] is a transfer in that cycle
- busy  out  1  high in RUN and REPORT
- done  out  1  one-cycle pulse marking window close
- count_odd  out  CW  odd-sample total of the last completed window
- count_even  out  CW  even-sample total of the last completed window
- timed_out  out  1  last window closed by timeout (only with PSCHED_TIMEOUT_EN, else tied 0)

## Operation
- FSM states: IDLE, RUN, REPORT. Reset state is IDLE.
- IDLE → RUN on start. Entering RUN clears the internal tallies (odd_t, even_t, n_acc).
- RUN:
  - If |req, gnt is one-hot per the round-robin rule; otherwise gnt=0.
  - The granted sample increments odd_t if d_in[4i] is 1, else even_t. 0 counts as even. n_acc increments.
  - RUN → REPORT in the cycle the WINDOW-th sample is accepted.
- REPORT, exactly one cycle:
  - done=1. count_odd/count_even load odd_t/even_t. gnt=0.
  - Then REPORT → IDLE.
- Round-robin rule:
  - Search starts at index (last_grant+1) mod N_REQ and picks the first asserted req.
  - last_grant updates only on a transfer.
  - After reset last_grant=N_REQ-1, so req[0] has first priority.
- start is ignored in RUN and REPORT. Windows do not queue.
- gnt is combinational from req and registered state. It is never asserted outside RUN.
- Invariant: at REPORT, count_odd+count_even equals samples accepted (WINDOW unless timed out).
- count_odd/count_even hold their value until the next REPORT. They are not cleared by start.

## Timing
- Reset values: gnt=0, busy=0, done=0, count_odd=0, count_even=0, timed_out=0, last_grant=N_REQ-1, FSM=IDLE.
- start sampled high at edge t: busy=1 and gnt may assert in cycle t+1.
- Throughput: one sample per cycle when any req is high.
- Last sample accepted in cycle k: done=1 in cycle k+1. Totals are valid in k+1 and held afterwards.
- The block returns to IDLE at k+2. A start in cycle k+2 opens a new window.
- With WINDOW=1, RUN lasts until the first transfer; REPORT follows in the next cycle.
- rst high in any state returns to IDLE in the next cycle with all reset values. No done is emitted for a partial window, and the prior totals are cleared.
- All req low in RUN: no grant, tallies hold, no state change unless the timeout fires.

## Configuration
- PSCHED_TIMEOUT_EN defined:
  - An idle counter in RUN counts consecutive cycles with req=0. It resets on any transfer and on RUN entry.
  - When it reaches TIMEOUT, the block goes RUN → REPORT. It reports partial totals with timed_out=1.
  - timed_out holds until the next REPORT.
- PSCHED_TIMEOUT_EN undefined:
  - No idle counter. A window closes only after WINDOW transfers.
  - timed_out is constant 0. The TIMEOUT parameter is unused.

## Structure
- Shared package psched_pkg holds:
  - state enum constants: S_IDLE=2'd0, S_RUN=2'd1, S_REPORT=2'd2
  - SAMPLE_W=4
- One sub-module, rr_arbiter: parameter N; inputs clk, rst, req, advance, en; output one-hot gnt.
  - It contains the last_grant pointer and the rotate-priority logic.
  - The top level holds the FSM, tallies, timeout counter and output registers.

## Test plan
- Reset, then start, with N_REQ=4, WINDOW=4. req=0001 with d_in[3:0] supplying 3, 10, 11, 10 → done one cycle after the 4th transfer, count_odd=2, count_even=2, then busy=0.
- req=1111 held, WINDOW=8 → gnt sequence 0001, 0010, 0100, 1000, 0001, … with one transfer per cycle; done at cycle 9 after start is registered.
- Mid-window reset: after 3 of 8 transfers assert rst → next cycle FSM=IDLE, all outputs 0, no done pulse. A following start gives a fresh window with totals counted from 0.
- start pulsed during RUN and REPORT → ignored. Exactly one done per accepted start; req=0 during REPORT yields gnt=0.
- WINDOW=1, sample 0 → count_odd=0, count_even=1. Then a sample of 15 in the next window → count_odd=1, count_even=0.
- PSCHED_TIMEOUT_EN, TIMEOUT=5, WINDOW=8: after 2 transfers (values 9, 4) drop all req → done 5 cycles later, count_odd=1, count_even=1, timed_out=1.
